sum_seg_display: RTL and testbench
==================================

# sum_seg_display

Downstream display stage for the 4-bit adder. Captures the 5-bit adder result ({cout, sum}) on a valid strobe and converts it to two BCD digits (0–31) with a sequential shift-add-3 (double-dabble) engine. It drives a two-digit, time-multiplexed, common-cathode seven-segment display through a free-running refresh counter.

## Interface
Parameters:
- REFRESH_W, 10: width of the refresh counter; the digit select toggles each time the counter wraps (every 2^REFRESH_W enabled cycles).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  design enable; low freezes all state.
- sum_in  input  5  adder result {cout, sum[3:0]}, unsigned 0–31.
- sum_valid  input  1  sum_in valid this cycle.
- busy  output  1  conversion in progress; sum_valid is ignored while high.
- done  output  1  one-cycle pulse when the display registers update.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- digit_en  output  2  one-hot digit select: 01 = units, 10 = tens.

## Operation
- FSM states:
  - IDLE → CONV on sum_valid & ena & !busy.
  - CONV → IDLE after the 5th shift.
- Accept: sum_in is loaded into the shift register, the BCD scratch is cleared, the shift count is set to 0, and busy goes high.
- CONV, each enabled cycle:
  - Each 4-bit BCD scratch digit ≥5 gets +3.
  - The {bcd, bin} register then shifts left by 1.
  - The count increments.
  - Each BCD digit is 4 bits wide. Tens never exceeds 3; units never exceeds 9.
- After the 5th shift:
  - The scratch is copied atomically into tens_q/units_q.
  - busy goes low and done pulses.
  - The display never shows a partial conversion.
- Refresh: the counter increments every enabled cycle. On wrap to 0, the digit select toggles units↔tens.
- seg is decoded combinationally from the selected digit register: 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66, 5:0x6D, 6:0x7D, 7:0x07, 8:0x7F, 9:0x6F. Codes 10–15 decode to 0x00.
- ena low holds every register, including the FSM, counters and done. The outputs keep their last values.

## Timing
- Reset values:
  - FSM IDLE, refresh counter 0, digit select units.
  - tens_q = units_q = 0, busy 0, done 0.
  - Outputs: seg 0x3F, digit_en 01.
- Latency (ena high throughout):
  - Accept at edge E0; busy = 1 after E0.
  - Shifts occur at E1…E5; tens_q/units_q update at E5.
  - After E5: busy = 0 and done = 1 for one cycle.
- Throughput: the next accept happens at E6 at the earliest, i.e. one result per 6 cycles.
- sum_valid during busy is dropped, not queued.
- Simultaneous refresh wrap and done: the toggle and the update both take effect. seg reflects the new digit value on the new digit.
- Reset mid-conversion aborts the conversion. The previous display value is lost and the block returns to the reset values.
- ena falling mid-CONV stalls the shift count. The conversion resumes exactly where it stopped.

## Configuration
- SUM_SEG_BLANK_EN defined: leading-zero blanking. When tens_q == 0 and the tens digit is selected, seg = 0x00; digit_en still reads 10.
- SUM_SEG_BLANK_EN undefined: the tens digit always shows its value, so 0 is shown as 0x3F.

## Structure
- Package sum_seg_pkg holds:
  - The FSM state enum (IDLE, CONV).
  - BCD_W = 4 and the CONV shift count 5.
  - The ten segment pattern constants SEG_0…SEG_9 and SEG_BLANK.
- Sub-module seg7_decode: combinational, 4-bit BCD in → 7-bit seg out. It is instantiated once, after the digit mux.
- Everything else (FSM, double-dabble datapath, refresh counter, digit registers) lives in sum_seg_display.

## Test plan
Scenarios 2–6 hold ena high throughout except where stated.

- Reset: assert rst_n low during CONV after accepting 23 → immediately busy 0, seg 0x3F, digit_en 01. After release, a new accept works.
- Decimal conversion, REFRESH_W = 4: sum_in 23 with a one-cycle valid →
  - busy high for exactly 5 cycles after the accept edge, then done pulses once.
  - Units shows 0x4F and tens shows 0x5B.
  - digit_en toggles every 16 cycles.
- Max value: sum_in 31 → units 0x06, tens 0x4F. sum_in 0 → both digits 0x3F (macro off).
- Drop while busy: accept 12, then hold sum_valid with sum_in 9 during busy, then release →
  - Display shows 1/2.
  - A 9 presented one cycle after done is accepted and shows units 0x6F.
- Blanking: sum_in 7 → tens digit seg 0x00 with SUM_SEG_BLANK_EN, 0x3F without it. Units shows 0x07 in both builds.
- Enable stall: drop ena for 50 cycles, 2 cycles after accepting 19 →
  - busy stays high and digit_en stays frozen while ena is low.
  - After ena returns, done arrives 3 enabled cycles later, with units 0x6F and tens 0x06.

Source files
------------

// File: rtl/sum_seg_pkg.sv
// Shared types and constants for the adder-result seven-segment display stage.
// Contents: FSM state enum, datapath widths, CONV shift count, segment patterns
// ({g,f,e,d,c,b,a}, active-high, common cathode) and the double-dabble +3 helper.
package sum_seg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam int unsigned BCD_W       = 4;
   localparam int unsigned SUM_W       = 5;
   localparam int unsigned CONV_SHIFTS = 5;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned SEG_W       = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Double-dabble correction: a digit of 5 or more would overflow past 9 on the next shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
      return (d >= BCD_W'(5)) ? BCD_W'(d + BCD_W'(3)) : d;
   endfunction

endpackage

// File: rtl/sum_seg_display_seg7_decode.sv
// seg7_decode: combinational BCD digit to seven-segment pattern.
// Ports:
//   bcd  in  4  BCD digit; codes 10-15 decode to all segments off
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
   import sum_seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_seg_display.sv
// sum_seg_display: captures the 5-bit adder result {cout,sum}, converts it to two
// BCD digits with a sequential double-dabble engine (5 shifts) and drives a
// two-digit time-multiplexed common-cathode seven-segment display.
// Parameters:
//   REFRESH_W  width of the refresh counter; digit select toggles on every wrap
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   ena        in   1  design enable; low freezes all state
//   sum_in     in   5  adder result, unsigned 0-31
//   sum_valid  in   1  sum_in valid this cycle (ignored while busy)
//   busy       out  1  conversion in progress
//   done       out  1  one-cycle pulse when the digit registers update
//   seg        out  7  segments {g,f,e,d,c,b,a}, decoded from the selected digit
//   digit_en   out  2  one-hot digit select: 01 units, 10 tens
// Build option:
//   SUM_SEG_BLANK_EN  blank the tens digit when it is zero (digit_en still 10)
module sum_seg_display
   import sum_seg_pkg::*;
#(
   parameter int unsigned REFRESH_W = 10
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [SUM_W-1:0] sum_in,
   input  logic             sum_valid,
   output logic             busy,
   output logic             done,
   output logic [SEG_W-1:0] seg,
   output logic [1:0]       digit_en
);

   localparam int unsigned SCR_W = 2 * BCD_W;
   localparam int unsigned SHR_W = SCR_W + SUM_W;

   state_t               state_q, state_d;
   logic [SUM_W-1:0]     bin_q, bin_d;
   logic [SCR_W-1:0]     bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BCD_W-1:0]     tens_q, tens_d;
   logic [BCD_W-1:0]     units_q, units_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [REFRESH_W-1:0] refresh_q, refresh_d;
   logic                 dsel_q, dsel_d;

   logic [SCR_W-1:0]     bcd_adj;
   logic [SHR_W-1:0]     shifted;
   logic [BCD_W-1:0]     digit_c;
   logic [SEG_W-1:0]     seg_dec_c;

   // State register: every register holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         tens_q    <= '0;
         units_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         refresh_q <= '0;
         dsel_q    <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         tens_q    <= tens_d;
         units_q   <= units_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         refresh_q <= refresh_d;
         dsel_q    <= dsel_d;
      end
   end

   // Next-state: FSM, double-dabble step, digit capture and refresh.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      tens_d    = tens_q;
      units_d   = units_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      refresh_d = refresh_q + REFRESH_W'(1);
      dsel_d    = (&refresh_q) ? ~dsel_q : dsel_q;

      bcd_adj = {add3(bcd_q[SCR_W-1 -: BCD_W]), add3(bcd_q[BCD_W-1:0])};
      shifted = {bcd_adj, bin_q} << 1;

      case (state_q)
         IDLE: begin
            if (sum_valid) begin
               state_d = CONV;
               bin_d   = sum_in;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CONV: begin
            bcd_d = shifted[SUM_W +: SCR_W];
            bin_d = shifted[SUM_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            // Last shift: publish both digits in the same edge so the display never shows a partial result.
            if (cnt_q == CNT_W'(CONV_SHIFTS - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tens_d  = shifted[SUM_W + BCD_W +: BCD_W];
               units_d = shifted[SUM_W +: BCD_W];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit mux ahead of the single decoder.
   assign digit_c = dsel_q ? tens_q : units_q;

   seg7_decode u_seg7_decode (
      .bcd (digit_c),
      .seg (seg_dec_c)
   );

`ifdef SUM_SEG_BLANK_EN
   assign seg = (dsel_q && (tens_q == '0)) ? SEG_BLANK : seg_dec_c;
`else
   assign seg = seg_dec_c;
`endif

   assign digit_en = dsel_q ? 2'b10 : 2'b01;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sum_seg_display.sv
// Scoreboard bench for sum_seg_display: a reference model counts enabled edges,
// decides acceptance from the latency/throughput rules and queues each accepted
// value; a negedge monitor pops on done and checks busy, done, digit_en and seg.
module tb_sum_seg_display;

   localparam int unsigned RW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b0;
   logic [4:0] sum_in = '0;
   logic       sum_valid = 1'b0;
   logic       busy, done;
   logic [6:0] seg;
   logic [1:0] digit_en;

   sum_seg_display #(.REFRESH_W(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .busy      (busy),
      .done      (done),
      .seg       (seg),
      .digit_en  (digit_en)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int edge_idx = 0;   // enabled clock edges since reset
   int free_at  = 0;   // first enabled edge index at which a new value can be accepted
   int q_val[$];
   int q_edge[$];
   int disp_t = 0;
   int disp_u = 0;
   bit started = 1'b0;
   bit prev_done = 1'b0;

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accept when idle, result visible 5 enabled edges later, next accept 6 later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_idx = 0;
         free_at  = 0;
         q_val.delete();
         q_edge.delete();
      end else if (ena) begin
         if (sum_valid && edge_idx >= free_at) begin
            q_val.push_back(int'(sum_in));
            q_edge.push_back(edge_idx);
            free_at = edge_idx + 6;
         end
         edge_idx++;
      end
   end

   // Monitor: pop on done, then compare all outputs against the model.
   always @(negedge clk) begin
      int v;
      int e;
      int exp_en;
      int exp_seg;
      if (started) begin
         if (!rst_n) begin
            disp_t    = 0;
            disp_u    = 0;
            prev_done = 1'b0;
         end else begin
            if (done && !prev_done) begin
               chk("scoreboard_nonempty", int'(q_val.size() > 0), 1);
               if (q_val.size() > 0) begin
                  v = q_val.pop_front();
                  e = q_edge.pop_front();
                  chk("done_latency", edge_idx - e - 1, 5);
                  disp_t = v / 10;
                  disp_u = v % 10;
               end
            end
            prev_done = done;
         end
         chk("busy", int'(busy), int'(edge_idx < free_at));
         chk("done", int'(done), int'(free_at != 0 && edge_idx == free_at));
         exp_en = (((edge_idx >> RW) & 1) != 0) ? 2 : 1;
         chk("digit_en", int'(digit_en), exp_en);
         exp_seg = (exp_en == 2) ? int'(pat(disp_t)) : int'(pat(disp_u));
`ifdef SUM_SEG_BLANK_EN
         if (exp_en == 2 && disp_t == 0) exp_seg = 0;
`endif
         chk("seg", int'(seg), exp_seg);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send(input int v);
      sum_in    = 5'(v);
      sum_valid = 1'b1;
      cyc(1);
      sum_valid = 1'b0;
   endtask

   task automatic reset_now();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_seg", int'(seg), 'h3F);
      chk("rst_digit_en", int'(digit_en), 1);
   endtask

   initial begin
      #2;
      reset_now();
      started = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      ena   = 1'b1;

      send(23);  cyc(40);
      send(31);  cyc(40);
      send(0);   cyc(40);
      send(7);   cyc(40);

      // Drop while busy, then a 9 one cycle after done.
      send(12);
      sum_in = 5'd9; sum_valid = 1'b1; cyc(4);
      sum_valid = 1'b0; cyc(1);
      send(9);   cyc(40);

      // Enable stall two cycles after accept.
      send(19);  cyc(2);
      ena = 1'b0; cyc(50);
      ena = 1'b1; cyc(40);

      // Reset mid-conversion, then a fresh accept.
      send(23);  cyc(2);
      reset_now();
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      send(5);   cyc(40);

      // Random traffic with occasional enable drops.
      repeat (400) begin
         ena       = ($urandom_range(0, 7) != 0);
         sum_valid = ($urandom_range(0, 2) == 0);
         sum_in    = 5'($urandom_range(0, 31));
         cyc(1);
      end
      ena = 1'b1; sum_valid = 1'b0;
      cyc(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
